// File: rtl/iter_shifter.sv
// -----------------------------------------------------------------------------
// iter_shifter
//   Multi-cycle shifter/rotator. A LEN-bit word is shifted by up to 2^AW-1
//   positions, moving at most MAX_SHIFT_MAG positions per clock so the
//   per-cycle shift network stays shallow. Valid/ready handshakes on both the
//   request and the result side.
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   request valid
//   in_ready   request can be accepted (IDLE only)
//   in_data    operand word
//   in_amt     total shift amount
//   in_mode    00 LSL, 01 LSR, 10 ASR, 11 ROL
//   out_valid  result valid (DONE only)
//   out_ready  consumer accepts result
//   out_data   result word (mirrors the working register)
//   busy       high while a request is in SHIFT or DONE
// -----------------------------------------------------------------------------
module iter_shifter #(
  parameter int LEN           = 8,
  parameter int MAX_SHIFT_MAG = 2,
  parameter int AW            = $clog2(LEN)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [LEN-1:0] in_data,
  input  logic [AW-1:0]  in_amt,
  input  logic [1:0]     in_mode,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [LEN-1:0] out_data,
  output logic           busy
);

  localparam logic [AW-1:0] STEP_MAX = AW'(MAX_SHIFT_MAG);

  localparam logic [1:0] MODE_LSL = 2'b00;
  localparam logic [1:0] MODE_LSR = 2'b01;
  localparam logic [1:0] MODE_ASR = 2'b10;
  localparam logic [1:0] MODE_ROL = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

  state_t         state_r;
  state_t         state_next_s;
  logic [LEN-1:0] data_r;
  logic [LEN-1:0] data_next_s;
  logic [AW-1:0]  rem_r;
  logic [AW-1:0]  rem_next_s;
  logic [1:0]     mode_r;
  logic [1:0]     mode_next_s;
  logic [AW-1:0]  step_s;
  logic           in_ready_r;
  logic           out_valid_r;
  logic           busy_r;

  // One bounded step of the selected operation. ASR stays sign-correct over
  // many steps because the MSB of the working word is never altered by ASR.
  function automatic logic [LEN-1:0] shift_step(
    input logic [LEN-1:0] d,
    input logic [AW-1:0]  s,
    input logic [1:0]     m
  );
    logic [2*LEN-1:0] dd;
    logic [LEN-1:0]   r;
    dd = {2*LEN{1'b0}};
    case (m)
      MODE_LSL: r = d << s;
      MODE_LSR: r = d >> s;
      MODE_ASR: r = LEN'($signed(d) >>> s);
      MODE_ROL: begin
        // Upper half of the doubled word shifted left is the rotated word.
        dd = {d, d} << s;
        r  = dd[2*LEN-1:LEN];
      end
      default:  r = d;
    endcase
    return r;
  endfunction

  // Step size for the current SHIFT cycle: min(rem, STEP_MAX).
  always_comb begin
    if (rem_r < STEP_MAX) begin
      step_s = rem_r;
    end else begin
      step_s = STEP_MAX;
    end
  end

  // Next-state and datapath-next logic.
  always_comb begin
    state_next_s = state_r;
    data_next_s  = data_r;
    rem_next_s   = rem_r;
    mode_next_s  = mode_r;
    case (state_r)
      ST_IDLE: begin
        if (in_valid) begin
          data_next_s = in_data;
          rem_next_s  = in_amt;
          mode_next_s = in_mode;
          if (in_amt != {AW{1'b0}}) begin
            state_next_s = ST_SHIFT;
          end else begin
            state_next_s = ST_DONE;
          end
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        data_next_s = shift_step(data_r, step_s, mode_r);
        rem_next_s  = rem_r - step_s;
        if (rem_r == step_s) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_SHIFT;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_DONE;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // State, datapath and registered handshake outputs (decoded from next state).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      data_r      <= {LEN{1'b0}};
      rem_r       <= {AW{1'b0}};
      mode_r      <= 2'b00;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      data_r      <= data_next_s;
      rem_r       <= rem_next_s;
      mode_r      <= mode_next_s;
      in_ready_r  <= (state_next_s == ST_IDLE);
      out_valid_r <= (state_next_s == ST_DONE);
      busy_r      <= (state_next_s != ST_IDLE);
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign busy      = busy_r;
  assign out_data  = data_r;

endmodule

// File: tb/tb_iter_shifter.sv
module tb_iter_shifter;

  localparam int LEN = 8;
  localparam int MAG = 2;
  localparam int AW  = 3;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [LEN-1:0] in_data;
  logic [AW-1:0]  in_amt;
  logic [1:0]     in_mode;
  logic           out_valid;
  logic           out_ready;
  logic [LEN-1:0] out_data;
  logic           busy;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  bit saw_valid;

  iter_shifter #(.LEN(LEN), .MAX_SHIFT_MAG(MAG), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_amt(in_amt), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) begin
      pass_cnt++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: result defined bit-by-bit from the operation's meaning.
  function automatic logic [LEN-1:0] ref_shift(input logic [LEN-1:0] d, input int amt, input logic [1:0] m);
    logic [LEN-1:0] r;
    r = '0;
    for (int i = 0; i < LEN; i++) begin
      case (m)
        2'b00: r[i] = (i - amt >= 0) ? d[i - amt] : 1'b0;
        2'b01: r[i] = (i + amt < LEN) ? d[i + amt] : 1'b0;
        2'b10: r[i] = (i + amt < LEN) ? d[i + amt] : d[LEN-1];
        default: r[(i + amt) % LEN] = d[i];
      endcase
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request, wait for the result, check data and latency, then drain.
  task automatic run_req(input logic [LEN-1:0] d, input int amt, input logic [1:0] m, input int hold);
    int n;
    logic [LEN-1:0] exp;
    exp = ref_shift(d, amt, m);
    chk("pre_in_ready", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_data  = d;
    in_amt   = AW'(amt);
    in_mode  = m;
    tick();
    in_valid = 1'b0;
    in_data  = $urandom;
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    chk("out_valid", {31'd0, out_valid}, 32'd1);
    chk("latency", n, (amt + MAG - 1) / MAG);
    chk("out_data", {24'd0, out_data}, {24'd0, exp});
    chk("done_in_ready", {30'd0, in_ready, busy}, 32'd1);
    for (int k = 0; k < hold; k++) begin
      tick();
      chk("hold_data", {23'd0, out_valid, out_data}, {23'd0, 1'b1, exp});
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("idle_after", {29'd0, in_ready, out_valid, busy}, 32'd4);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b1; in_data = 8'hFF; in_amt = 3'd3;
    in_mode = 2'b00; out_ready = 1'b0;
    tick(); tick();
    chk("rst_outs", {23'd0, out_valid, busy, out_data}, 32'd0);
    in_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_idle_stays", {30'd0, out_valid, busy}, 32'd0);

    // Directed test-plan vectors, with explicit constants too.
    run_req(8'b0000_0001, 5, 2'b00, 0);
    chk("lsl5_const", {24'd0, ref_shift(8'b0000_0001, 5, 2'b00)}, 32'h20);
    run_req(8'b1000_0000, 3, 2'b10, 0);
    run_req(8'b1000_0000, 3, 2'b01, 0);
    run_req(8'b1010_0101, 0, 2'b00, 0);
    run_req(8'b1000_0001, 7, 2'b11, 0);
    run_req(8'b0000_0011, 1, 2'b11, 0);

    // Backpressure with an ignored second request.
    in_valid = 1'b1; in_data = 8'b0000_0001; in_amt = 3'd2; in_mode = 2'b00;
    tick();
    in_valid = 1'b0;
    tick();
    for (int k = 0; k < 5; k++) begin
      chk("bp_hold", {22'd0, out_valid, in_ready, out_data}, {22'd0, 1'b1, 1'b0, 8'h04});
      in_valid = (k == 1); in_data = 8'hAA; in_amt = 3'd0; in_mode = 2'b01;
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_idle", {30'd0, in_ready, out_valid}, 32'd2);
    tick();
    chk("bp_no_ghost", {30'd0, in_ready, out_valid}, 32'd2);

    // Reset in the 2nd SHIFT cycle of ROL 7.
    saw_valid = 1'b0;
    in_valid = 1'b1; in_data = 8'b1000_0001; in_amt = 3'd7; in_mode = 2'b11;
    tick();
    in_valid = 1'b0;
    saw_valid |= out_valid;
    tick();
    saw_valid |= out_valid;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    saw_valid |= out_valid;
    chk("midrst_state", {29'd0, out_valid, busy, in_ready}, 32'd1);
    for (int k = 0; k < 4; k++) begin
      tick();
      saw_valid |= out_valid;
    end
    chk("midrst_never_valid", {31'd0, saw_valid}, 32'd0);
    run_req(8'b0110_1001, 6, 2'b10, 1);

    // Randomized requests against the reference.
    for (int t = 0; t < 40; t++) begin
      run_req(LEN'($urandom), int'($urandom_range(0, 7)), 2'($urandom), int'($urandom_range(0, 3)));
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
